alu_input_sequencer: RTL and testbench

// Parametrised successor to the 6-bit switch/button ALU front end. It synchronises and edge-detects the

---
 rtl/alu_input_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_input_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_input_sequencer.sv
// ALU front end: synchronises and edge-detects three buttons, enforces A -> B -> OP
// entry order, and registers the ALU result with zero/carry/overflow flags.
module alu_input_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] switches,
  input  logic [2:0]            buttons,
  output logic [DATA_WIDTH-1:0] LEDS,
  output logic                  zero,
  output logic                  carry,
  output logic                  overflow,
  output logic                  error,
  output logic [1:0]            state
);

  localparam int unsigned Msb = DATA_WIDTH - 1;
  localparam int unsigned Dw1 = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH:0] WidthVal = Dw1'(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OpAdd = OP_WIDTH'(6'b100000);
  localparam logic [OP_WIDTH-1:0] OpSub = OP_WIDTH'(6'b100010);
  localparam logic [OP_WIDTH-1:0] OpAnd = OP_WIDTH'(6'b100100);
  localparam logic [OP_WIDTH-1:0] OpOr  = OP_WIDTH'(6'b100101);
  localparam logic [OP_WIDTH-1:0] OpXor = OP_WIDTH'(6'b100110);
  localparam logic [OP_WIDTH-1:0] OpSra = OP_WIDTH'(6'b000011);
  localparam logic [OP_WIDTH-1:0] OpSrl = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OpNor = OP_WIDTH'(6'b100111);

  typedef enum logic [1:0] {
    StWaitA  = 2'd0,
    StWaitB  = 2'd1,
    StWaitOp = 2'd2,
    StShow   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, leds_q, leds_d;
  logic                  zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;

  logic [2:0] sync_q [SYNC_STAGES];
  logic [2:0] btn_prev_q;
  logic [2:0] pulse;
  logic       multi, p_a, p_b, p_op;

  // Button synchroniser chain plus previous-level register for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      btn_prev_q <= '0;
    end else begin
      sync_q[0] <= buttons;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      btn_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising-edge pulses; more than one bit set in a cycle is treated as a multi-press.
  always_comb begin
    pulse = sync_q[SYNC_STAGES-1] & ~btn_prev_q;
    multi = |(pulse & (pulse - 3'd1));
    p_a   = pulse == 3'b100;
    p_b   = pulse == 3'b010;
    p_op  = pulse == 3'b001;
  end

  logic [OP_WIDTH-1:0]   op;
  logic [DATA_WIDTH:0]   sum, diff;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_c, res_v, legal, b_big;

  // ALU on the loaded operands, opcode taken live from the switches.
  always_comb begin
    op    = switches[OP_WIDTH-1:0];
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    b_big = {1'b0, b_q} >= WidthVal;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    legal = 1'b1;
    case (op)
      OpAdd: begin
        res   = sum[DATA_WIDTH-1:0];
        res_c = sum[DATA_WIDTH];
        res_v = (a_q[Msb] == b_q[Msb]) && (sum[Msb] != a_q[Msb]);
      end
      OpSub: begin
        res   = diff[DATA_WIDTH-1:0];
        res_c = diff[DATA_WIDTH];  // borrow, i.e. A < B unsigned
        res_v = (a_q[Msb] != b_q[Msb]) && (diff[Msb] != a_q[Msb]);
      end
      OpAnd: res = a_q & b_q;
      OpOr:  res = a_q | b_q;
      OpXor: res = a_q ^ b_q;
      OpNor: res = ~(a_q | b_q);
      OpSra: res = b_big ? {DATA_WIDTH{a_q[Msb]}} : $unsigned($signed(a_q) >>> b_q);
      OpSrl: res = b_big ? '0 : (a_q >> b_q);
      default: legal = 1'b0;
    endcase
  end

  // Entry-order FSM; unexpected or simultaneous pulses only set the sticky error.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    leds_d  = leds_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (multi) begin
      err_d = 1'b1;
    end else if (|pulse) begin
      unique case (state_q)
        StWaitA, StShow: begin
          if (p_a) begin
            a_d     = switches;
            state_d = StWaitB;
          end else err_d = 1'b1;
        end
        StWaitB: begin
          if (p_b) begin
            b_d     = switches;
            state_d = StWaitOp;
          end else err_d = 1'b1;
        end
        StWaitOp: begin
          if (p_op) begin
            state_d = StShow;
            if (legal) begin
              leds_d  = res;
              zero_d  = res == '0;
              carry_d = res_c;
              ovf_d   = res_v;
            end else err_d = 1'b1;
          end else err_d = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StWaitA;
      a_q     <= '0;
      b_q     <= '0;
      leds_q  <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      leds_q  <= leds_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  assign LEDS     = leds_q;
  assign zero     = zero_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign error    = err_q;
  assign state    = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Scoreboard bench for alu_input_sequencer (DATA_WIDTH=8, SYNC_STAGES=2).
module tb_alu_input_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] sw  = '0;
  logic [2:0] btn = '0;
  logic [7:0] leds;
  logic       zero, carry, ovf, err;
  logic [1:0] st;

  alu_input_sequencer #(
    .DATA_WIDTH (8),
    .OP_WIDTH   (6),
    .SYNC_STAGES(2)
  ) dut (
    .clock   (clk),
    .reset   (rst),
    .switches(sw),
    .buttons (btn),
    .LEDS    (leds),
    .zero    (zero),
    .carry   (carry),
    .overflow(ovf),
    .error   (err),
    .state   (st)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] OpAdd = 8'h20, OpSub = 8'h22, OpSra = 8'h03, OpSrl = 8'h02;
  localparam logic [7:0] OpNor = 8'h27, OpBad = 8'h3F;
  localparam logic [2:0] BtnA = 3'b100, BtnB = 3'b010, BtnOp = 3'b001;

  typedef struct packed {
    logic [7:0] leds;
    logic       z, c, v, e;
    logic [1:0] st;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic expect_out(input string tag, input logic [7:0] l, input logic z, input logic c,
                            input logic v, input logic e, input logic [1:0] s);
    exp_t x;
    x = '{leds: l, z: z, c: c, v: v, e: e, st: s};
    exp_q.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic compare_next();
    exp_t  x;
    string t;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      x = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".leds"}, {24'd0, leds}, {24'd0, x.leds});
      check({t, ".zero"}, {31'd0, zero}, {31'd0, x.z});
      check({t, ".carry"}, {31'd0, carry}, {31'd0, x.c});
      check({t, ".ovf"}, {31'd0, ovf}, {31'd0, x.v});
      check({t, ".err"}, {31'd0, err}, {31'd0, x.e});
      check({t, ".state"}, {30'd0, st}, {30'd0, x.st});
    end
  endtask

  // Hold a button mask for 4 cycles, release for 4; optionally compare at the 3rd edge.
  task automatic press(input logic [2:0] m, input logic [7:0] s, input bit chk, input int pre_st);
    @(negedge clk);
    sw  = s;
    btn = m;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 2 && pre_st >= 0) check("latency_pre", {30'd0, st}, pre_st);
      if (i == 3 && chk) compare_next();
    end
    @(negedge clk);
    btn = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b1;
    btn = '0;
    @(posedge clk);
    #1;
    if (chk) compare_next();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    press(BtnA, a, 1'b0, -1);
    press(BtnB, b, 1'b0, -1);
    press(BtnOp, op, 1'b1, -1);
  endtask

  initial begin
    expect_out("reset", 8'h00, 0, 0, 0, 0, 2'd0);
    do_reset(1'b1);

    press(BtnA, 8'h7F, 1'b0, -1);
    press(BtnB, 8'h01, 1'b0, -1);
    expect_out("add_ovf", 8'h80, 0, 0, 1, 0, 2'd3);
    press(BtnOp, OpAdd, 1'b1, 2);

    expect_out("sub_zero", 8'h00, 1, 0, 0, 0, 2'd3);
    run_op(8'h05, 8'h05, OpSub);
    expect_out("sub_borrow", 8'hFE, 0, 1, 0, 0, 2'd3);
    run_op(8'h03, 8'h05, OpSub);
    expect_out("sra2", 8'hE4, 0, 0, 0, 0, 2'd3);
    run_op(8'h90, 8'h02, OpSra);
    expect_out("srl2", 8'h24, 0, 0, 0, 0, 2'd3);
    run_op(8'h90, 8'h02, OpSrl);
    expect_out("sra9", 8'hFF, 0, 0, 0, 0, 2'd3);
    run_op(8'h90, 8'h09, OpSra);
    expect_out("srl9", 8'h00, 1, 0, 0, 0, 2'd3);
    run_op(8'h90, 8'h09, OpSrl);

    do_reset(1'b0);
    expect_out("b_first", 8'h00, 0, 0, 0, 1, 2'd0);
    press(BtnB, 8'h55, 1'b1, -1);
    expect_out("nor", 8'h00, 1, 0, 0, 1, 2'd3);
    run_op(8'h0F, 8'hF0, OpNor);

    do_reset(1'b0);
    expect_out("illegal_clean", 8'h00, 0, 0, 0, 1, 2'd3);
    run_op(8'h01, 8'h02, OpBad);

    do_reset(1'b0);
    press(BtnA, 8'h11, 1'b0, -1);
    expect_out("multi_press", 8'h00, 0, 0, 0, 1, 2'd1);
    press(BtnA | BtnB, 8'h22, 1'b1, -1);
    press(BtnB, 8'h01, 1'b0, -1);
    expect_out("a_kept", 8'h12, 0, 0, 0, 1, 2'd3);
    press(BtnOp, OpAdd, 1'b1, -1);
    expect_out("illegal_hold", 8'h12, 0, 0, 0, 1, 2'd3);
    run_op(8'h33, 8'h44, OpBad);

    // Reset while in WAIT_OP with the A button already held down.
    press(BtnA, 8'h01, 1'b0, -1);
    press(BtnB, 8'h02, 1'b0, -1);
    expect_out("reset_waitop", 8'h00, 0, 0, 0, 0, 2'd0);
    @(negedge clk);
    rst = 1'b1;
    btn = BtnA;
    sw  = 8'h05;
    @(posedge clk);
    #1;
    compare_next();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    expect_out("held_a_once", 8'h00, 0, 0, 0, 0, 2'd1);
    compare_next();
    btn = '0;
    repeat (4) @(negedge clk);
    press(BtnB, 8'h03, 1'b0, -1);
    expect_out("after_reset_add", 8'h08, 0, 0, 0, 0, 2'd3);
    press(BtnOp, OpAdd, 1'b1, -1);

    if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
